encoder_64_6_seq: RTL and testbench
===================================

Name: encoder_64_6_seq

Overview:
Sequential 64:6 encoder, the inverse of the team's 6:64 decoder. It captures a 64-bit request vector on `start` and emits the 6-bit index of every set bit, lowest index first, one per accepted handshake. It serves as the back end that turns one-hot or multi-hot decoder-style vectors back into binary indices for downstream consumers.

Parameters:
N, 64, input vector width (supported: power of 2, 4..64).
W, 6, index width, equal to $clog2(N).

Ports:
clk        input   1      clock; all state updates on the rising edge.
reset      input   1      asynchronous, active-high; clears all state immediately.
start      input   1      capture `req` and begin an operation; honoured only in IDLE.
req        input   N      request vector, sampled on the start cycle only.
idx_ready  input   1      consumer can accept `idx` this cycle.
idx_valid  output  1      `idx` holds a valid index.
idx        output  W      index of the lowest still-pending set bit; 0 when `idx_valid`=0.
busy       output  1      1 in SCAN and DONE, 0 in IDLE.
done       output  1      single-cycle pulse when an operation completes.
none       output  1      the last captured `req` was all zero; held until the next accepted start.
count      output  W+1    indices emitted in the current/last operation (0..N).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, pending=0, count=0, none=0.
  - idx_valid=0, idx=0, busy=0, done=0.
  - Outputs take these values during the reset-asserted interval itself, not at the next edge.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 loads pending<=req, count<=0, none<=(req==0).
  - Next state is SCAN if req!=0, else DONE.
  - start=0 keeps the block in IDLE.
- SCAN:
  - idx_valid=1.
  - idx = lowest set bit index of `pending`, from a combinational priority encode of the registered pending value.
  - On idx_valid && idx_ready: clear that bit in pending and increment count.
  - If the cleared bit was the last set bit, go to DONE; otherwise stay in SCAN.
  - Without idx_ready: idx and idx_valid hold stable; nothing changes.
- DONE:
  - done=1 for exactly one cycle, idx_valid=0.
  - Next state is unconditionally IDLE.
- start outside IDLE: ignored. `req` changes outside the start cycle have no effect.
- Latency:
  - start accepted at edge t gives the first idx_valid in cycle t+1.
  - With idx_ready held high, one index is emitted per cycle.
  - For k set bits, done is asserted in cycle t+1+k.
  - req==0: done in cycle t+1, no idx_valid at any point.
- Back-to-back: the earliest next start is the cycle after DONE (IDLE). Minimum operation period is k+2 cycles.
- count:
  - W+1 bits, so it can reach 64 with no wrap.
  - Holds its final value after DONE until the next accepted start.
- idx ordering: strictly increasing within an operation; each set bit is emitted exactly once.
- Reset mid-operation: pending is discarded, no done pulse is produced, and the block restarts in IDLE.

Test Plan:
1. req=64'h1, start, idx_ready=1 -> cycle t+1: idx_valid=1, idx=0. Cycle t+2: done=1, count=1, none=0.
2. req=64'h8000_0000_0000_0001, idx_ready=1 -> idx=0 at t+1, idx=63 at t+2, done at t+3, count=2.
3. req=all ones, idx_ready=1 -> idx=0..63 on 64 consecutive cycles, done at t+65, count=64 with no overflow.
4. req=0, start -> done at t+1, none=1, idx_valid never 1, count=0. A following start with req=64'h4 -> none=0, idx=2.
5. req=64'h14, idx_ready=0 for 3 cycles then 1, with start pulsed during SCAN -> idx=2 held stable for 3 cycles, then idx=4, done, count=2. The stray start causes no restart.
6. req=64'hFF00, reset asserted after 3 indices (8, 9, 10) -> outputs 0 during reset, no done pulse. After release, start with req=64'h2 -> idx=1, count=1.

Source files
------------

// File: rtl/encoder_64_6_seq.sv
// rtl/encoder_64_6_seq.sv - sequential 64:6 encoder emitting set-bit indices lowest first
module encoder_64_6_seq #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] req,
    input  logic         idx_ready,
    output logic         idx_valid,
    output logic [W-1:0] idx,
    output logic         busy,
    output logic         done,
    output logic         none,
    output logic [W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending;
    logic [N-1:0] pending_clr;
    logic [W-1:0] low_idx;
    logic         accept;

    // Walk downward so the final assignment is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, which is the one being emitted.
    assign pending_clr = pending & (pending - N'(1));
    assign accept      = (state == SCAN) && idx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_valid = 1'b0;
        idx       = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (req != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                busy      = 1'b1;
                idx_valid = 1'b1;
                idx       = low_idx;
                if (idx_ready && (pending_clr == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            count   <= '0;
            none    <= 1'b0;
        end else if ((state == IDLE) && start) begin
            pending <= req;
            count   <= '0;
            none    <= (req == '0);
        end else if (accept) begin
            pending <= pending_clr;
            count   <= count + (W + 1)'(1);
        end
    end

endmodule

// File: tb/tb_encoder_64_6_seq.sv
// tb/tb_encoder_64_6_seq.sv - directed vector bench for encoder_64_6_seq
module tb_encoder_64_6_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] req = '0;
    logic        idx_ready = 1'b0;
    logic        idx_valid;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
    logic        none;
    logic [6:0]  count;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] req;
        int          k;
        int          first;
        int          last;
        logic        none;
    } vec_t;

    vec_t vecs[7];

    encoder_64_6_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req       (req),
        .idx_ready (idx_ready),
        .idx_valid (idx_valid),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .none      (none),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [63:0] m);
        for (int i = 0; i < 64; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [63:0] remaining;
        int          n;
        int          first;
        int          last;
        int          cyc;
        bit          got_done;
        remaining = v.req;
        n         = 0;
        first     = -1;
        last      = -1;
        cyc       = 0;
        got_done  = 0;
        req       = v.req;
        start     = 1'b1;
        idx_ready = 1'b1;
        tick();
        start = 1'b0;
        req   = ~v.req;
        while (!got_done && cyc < 200) begin
            if (idx_valid) begin
                chk("idx_order", {58'd0, idx}, 64'(lowest(remaining)));
                if (n == 0) first = int'(idx);
                last = int'(idx);
                remaining[idx] = 1'b0;
                n++;
                tick();
                cyc++;
            end else if (done) begin
                chk("done_cycle", 64'(cyc), 64'(v.k));
                got_done = 1;
            end else begin
                chk("idx_valid_in_scan", {63'd0, idx_valid}, 64'd1);
                tick();
                cyc++;
            end
        end
        if (!got_done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles required %0d", cyc, v.k);
        end
        chk("count", {57'd0, count}, 64'(v.k));
        chk("none", {63'd0, none}, {63'd0, v.none});
        chk("emitted_all", remaining, 64'd0);
        if (v.k > 0) begin
            chk("first_idx", 64'(first), 64'(v.first));
            chk("last_idx", 64'(last), 64'(v.last));
        end
        tick();
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("done_pulse_width", {63'd0, done}, 64'd0);
        chk("count_hold", {57'd0, count}, 64'(v.k));
    endtask

    initial begin
        vecs[0] = '{64'h1, 1, 0, 0, 1'b0};
        vecs[1] = '{64'h8000_0000_0000_0001, 2, 0, 63, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 63, 1'b0};
        vecs[3] = '{64'h0000_0100_0000_0010, 2, 4, 40, 1'b0};
        vecs[4] = '{64'hA5, 4, 0, 7, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 1, 63, 63, 1'b0};
        vecs[6] = '{64'h0, 0, 0, 0, 1'b1};

        // Asynchronous reset: outputs must clear before any clock edge.
        #1;
        reset = 1'b1;
        #1;
        chk("rst_idx_valid", {63'd0, idx_valid}, 64'd0);
        chk("rst_idx", {58'd0, idx}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_none", {63'd0, none}, 64'd0);
        chk("rst_count", {57'd0, count}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Zero request followed by a normal one clears none.
        req   = 64'h4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("after_zero_none", {63'd0, none}, 64'd0);
        chk("after_zero_valid", {63'd0, idx_valid}, 64'd1);
        chk("after_zero_idx", {58'd0, idx}, 64'd2);
        tick();
        chk("after_zero_done", {63'd0, done}, 64'd1);
        chk("after_zero_count", {57'd0, count}, 64'd1);
        tick();

        // Back-pressure with a stray start during SCAN.
        req       = 64'h14;
        idx_ready = 1'b0;
        start     = 1'b1;
        tick();
        chk("stall_idx_0", {58'd0, idx}, 64'd2);
        chk("stall_valid_0", {63'd0, idx_valid}, 64'd1);
        req = 64'hFF;
        tick();
        start = 1'b0;
        chk("stall_idx_1", {58'd0, idx}, 64'd2);
        chk("stall_count_1", {57'd0, count}, 64'd0);
        tick();
        chk("stall_idx_2", {58'd0, idx}, 64'd2);
        chk("stall_valid_2", {63'd0, idx_valid}, 64'd1);
        idx_ready = 1'b1;
        tick();
        chk("stall_idx_3", {58'd0, idx}, 64'd4);
        tick();
        chk("stall_done", {63'd0, done}, 64'd1);
        chk("stall_done_valid", {63'd0, idx_valid}, 64'd0);
        chk("stall_count", {57'd0, count}, 64'd2);
        tick();
        chk("stall_no_restart", {63'd0, busy}, 64'd0);
        chk("stall_count_hold", {57'd0, count}, 64'd2);

        // Reset in the middle of an operation.
        req   = 64'hFF00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("midrst_idx", {58'd0, idx}, 64'(8 + j));
            if (j < 3) tick();
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, idx_valid}, 64'd0);
        chk("midrst_idx_zero", {58'd0, idx}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_count", {57'd0, count}, 64'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("midrst_no_done", {63'd0, done}, 64'd0);
        end
        reset = 1'b0;
        tick();
        chk("postrst_no_done", {63'd0, done}, 64'd0);
        chk("postrst_idle", {63'd0, busy}, 64'd0);
        run_vec('{64'h2, 1, 1, 1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
